// File: rtl/rf_host_cmd_initiator.sv
// rf_host_cmd_initiator: MCU-side initiator for the RF transceiver
// M0/M1/AUX mode pins plus UART command/reply exchange.
module rf_host_cmd_initiator #(
  parameter logic [7:0] HEAD_SAVE      = 8'hC0,
  parameter logic [7:0] HEAD_NOSAVE    = 8'hC2,
  parameter logic [7:0] RET_CONFIG     = 8'hC1,
  parameter logic [7:0] RET_VERSION    = 8'hC3,
  parameter logic [7:0] RESET_CMD      = 8'hC4,
  parameter int         AUX_SETTLE     = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        internal_clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [39:0] cmd_cfg,
  input  logic [1:0]  cmd_mode,
  output logic        M0,
  output logic        M1,
  input  logic        AUX,
  output logic [7:0]  tx_data,
  output logic        tx_use,
  input  logic        tx_full,
  input  logic [7:0]  rx_data,
  input  logic        rx_flag,
  output logic        rx_use,
  output logic [47:0] rsp_data,
  output logic        rsp_valid,
  output logic        err_timeout
);

  localparam int SW = $clog2(AUX_SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(AUX_SETTLE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, PROG_ENTER, SEND, RECV, DRAIN, RESTORE, DONE
  } state_t;

  state_t state, state_n;

  logic          aux_s1, aux_s2;
  logic [2:0]    op_q;
  logic [39:0]   cfg_q;
  logic [1:0]    user_mode, um_n;
  logic [1:0]    mode_pins;
  logic [2:0]    idx;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          aux_low_seen;

  logic          accept, push, pop, tmo_abort;
  logic          wait_st, tmo_hit;
  logic          settle_en, settled;
  logic [7:0]    tx_byte;
  logic          tx_last;
  logic [2:0]    rx_need;
  logic [39:0]   cfg_sh;
  logic          cfg_op;

  assign cfg_op = (op_q == 3'd0) || (op_q == 3'd1);
  // Byte 0 is the header, bytes 1..5 walk ADDH..OPTION.
  assign cfg_sh = cfg_q << {idx - 3'd1, 3'b000};

  // Outgoing byte selection and per-op stream/reply lengths.
  always_comb begin
    tx_byte = 8'h00;
    tx_last = 1'b0;
    rx_need = 3'd4;
    unique case (1'b1)
      op_q == 3'd0: begin
        tx_byte = (idx == 3'd0) ? HEAD_SAVE : cfg_sh[39:32];
        tx_last = idx == 3'd5;
      end
      op_q == 3'd1: begin
        tx_byte = (idx == 3'd0) ? HEAD_NOSAVE : cfg_sh[39:32];
        tx_last = idx == 3'd5;
      end
      op_q == 3'd2: begin
        tx_byte = RET_CONFIG;
        tx_last = idx == 3'd2;
        rx_need = 3'd6;
      end
      op_q == 3'd3: begin
        tx_byte = RET_VERSION;
        tx_last = idx == 3'd2;
      end
      default: begin
        tx_byte = RESET_CMD;
        tx_last = idx == 3'd2;
      end
    endcase
  end

  // Next-state and handshake strobes.
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    tmo_abort = 1'b0;
    um_n      = user_mode;
    wait_st   = state inside {PROG_ENTER, SEND, RECV, DRAIN, RESTORE};
    tmo_hit   = wait_st && (tmo_cnt == TMO_LAST);
    settle_en = aux_s2 &&
                !(state == DRAIN && op_q == 3'd4 && !aux_low_seen);
    settled   = settle_en && (settle_cnt == SETTLE_LAST);
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_op >= 3'd5) begin
            state_n = RESTORE;
            um_n    = cmd_mode;
          end else begin
            state_n = PROG_ENTER;
          end
        end
      end
      PROG_ENTER: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_n   = RESTORE;
        end else if (settled) begin
          state_n = SEND;
        end
      end
      SEND: begin
        push = !tx_full;
        if (push && tx_last) begin
          state_n = (op_q == 3'd2 || op_q == 3'd3) ? RECV : DRAIN;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_n   = RESTORE;
        end
      end
      RECV: begin
        pop = rx_flag && (idx < rx_need);
        if (pop && idx == rx_need - 3'd1) begin
          state_n = DRAIN;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_n   = RESTORE;
        end
      end
      DRAIN: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_n   = RESTORE;
        end else if (settled) begin
          state_n = RESTORE;
        end
      end
      RESTORE: begin
        if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_n   = DONE;
        end else if (settled) begin
          state_n = DONE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // AUX is asynchronous to internal_clk.
  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      aux_s1 <= 1'b0;
      aux_s2 <= 1'b0;
    end else begin
      aux_s1 <= AUX;
      aux_s2 <= aux_s1;
    end
  end

  // State register.
  always_ff @(posedge internal_clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Command latches, counters, reply assembly and mode pins.
  always_ff @(posedge internal_clk) begin
    if (!rst_n) begin
      op_q         <= 3'd0;
      cfg_q        <= 40'h0;
      user_mode    <= 2'b00;
      mode_pins    <= 2'b00;
      idx          <= 3'd0;
      settle_cnt   <= '0;
      tmo_cnt      <= '0;
      aux_low_seen <= 1'b0;
      rsp_data     <= 48'h0;
      err_timeout  <= 1'b0;
    end else begin
      user_mode <= um_n;
      mode_pins <= (state_n inside {PROG_ENTER, SEND, RECV, DRAIN})
                   ? 2'b11 : um_n;

      if (state_n != state)            settle_cnt <= '0;
      else if (settle_en && wait_st)   settle_cnt <= settle_cnt + SW'(1);
      else                             settle_cnt <= '0;

      if (state_n != state || push || pop) tmo_cnt <= '0;
      else if (wait_st)                    tmo_cnt <= tmo_cnt + TW'(1);

      if (accept) begin
        op_q         <= cmd_op;
        cfg_q        <= cmd_cfg;
        rsp_data     <= 48'h0;
        err_timeout  <= 1'b0;
        aux_low_seen <= 1'b0;
        idx          <= 3'd0;
      end

      if (push) idx <= tx_last ? 3'd0 : idx + 3'd1;

      if (pop) begin
        rsp_data <= rsp_data | ({rx_data, 40'h0} >> {idx, 3'b000});
        idx      <= idx + 3'd1;
      end

      if (state == DRAIN && !aux_s2) aux_low_seen <= 1'b1;
      if (tmo_abort) err_timeout <= 1'b1;
    end
  end

  assign cmd_ready = state == IDLE;
  assign tx_use    = rst_n && push;
  assign tx_data   = (state == SEND) ? tx_byte : 8'h00;
  assign rx_use    = rst_n && pop;
  assign rsp_valid = state == DONE;
  assign M1        = mode_pins[1];
  assign M0        = mode_pins[0];

endmodule

// File: tb/tb_rf_host_cmd_initiator.sv
// tb_rf_host_cmd_initiator: scoreboard bench for rf_host_cmd_initiator
// with a small RX FIFO model and directed command vectors.
module tb_rf_host_cmd_initiator;

  logic        internal_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [39:0] cmd_cfg = 40'h0;
  logic [1:0]  cmd_mode = 2'b00;
  logic        M0, M1;
  logic        AUX = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_use;
  logic        tx_full = 1'b0;
  logic [7:0]  rx_data;
  logic        rx_flag;
  logic        rx_use;
  logic [47:0] rsp_data;
  logic        rsp_valid;
  logic        err_timeout;

  always #5 internal_clk = ~internal_clk;

  rf_host_cmd_initiator #(
    .AUX_SETTLE(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .internal_clk(internal_clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_cfg(cmd_cfg),
    .cmd_mode(cmd_mode),
    .M0(M0),
    .M1(M1),
    .AUX(AUX),
    .tx_data(tx_data),
    .tx_use(tx_use),
    .tx_full(tx_full),
    .rx_data(rx_data),
    .rx_flag(rx_flag),
    .rx_use(rx_use),
    .rsp_data(rsp_data),
    .rsp_valid(rsp_valid),
    .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [47:0] data;
    logic        err;
    logic [1:0]  pins;
  } rsp_t;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];

  int vecs = 0;
  int errs = 0;
  int tx_seen = 0;
  int rsp_seen = 0;

  logic       chk_idle = 1'b0;
  logic [1:0] idle_pins = 2'b00;
  logic       chk_wait = 1'b0;
  logic       wait_ok = 1'b0;
  logic       chk_end = 1'b0;

  // RX FIFO model: stimulus writes, DUT pops.
  logic [7:0] rx_mem [16];
  int rx_wr = 0;
  int rx_rd = 0;
  assign rx_flag = rx_rd != rx_wr;
  assign rx_data = rx_mem[rx_rd[3:0]];

  always @(posedge internal_clk) begin
    if (rx_use) rx_rd <= rx_rd + 1;
  end

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] want);
    vecs++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents output.
  initial begin
    logic [7:0] e;
    rsp_t       r;
    logic       rsp_prev;
    rsp_prev = 1'b0;
    forever begin
      @(negedge internal_clk);
      if (rsp_prev) chk("rsp_pulse", 64'(rsp_valid), 64'd0);
      rsp_prev = rsp_valid;
      if (tx_use) begin
        tx_seen++;
        if (exp_tx.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL tx_unexp: got %0h want none", tx_data);
        end else begin
          e = exp_tx.pop_front();
          chk("tx_data", 64'(tx_data), 64'(e));
          chk("tx_pins", 64'({M1, M0}), 64'd3);
        end
      end
      if (rsp_valid) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL rsp_unexp: got %0h want none", rsp_data);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_data", 64'(rsp_data), 64'(r.data));
          chk("rsp_err", 64'(err_timeout), 64'(r.err));
          chk("rsp_pins", 64'({M1, M0}), 64'(r.pins));
        end
      end
      if (chk_idle) begin
        chk("idle_ready", 64'(cmd_ready), 64'd1);
        chk("idle_pins", 64'({M1, M0}), 64'(idle_pins));
        chk("idle_rsp", 64'(rsp_data), 64'd0);
        chk("idle_err", 64'(err_timeout), 64'd0);
        chk("idle_txuse", 64'(tx_use), 64'd0);
      end
      if (chk_wait) chk("rsp_wait", 64'(wait_ok), 64'd1);
      if (chk_end) begin
        chk("end_tx_left", 64'(exp_tx.size()), 64'd0);
        chk("end_rsp_left", 64'(exp_rsp.size()), 64'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge internal_clk);
    #1;
  endtask

  task automatic rx_load(input logic [7:0] b);
    rx_mem[rx_wr % 16] = b;
    rx_wr++;
  endtask

  task automatic tx_exp(input logic [7:0] b);
    exp_tx.push_back(b);
  endtask

  task automatic rsp_exp(input logic [47:0] d, input logic er,
                         input logic [1:0] p);
    rsp_t r;
    r.data = d;
    r.err  = er;
    r.pins = p;
    exp_rsp.push_back(r);
  endtask

  // Caller is one step after a rising edge with the DUT idle.
  task automatic issue(input logic [2:0] op, input logic [39:0] cfg,
                       input logic [1:0] mode, input int hold);
    cmd_op    = op;
    cmd_cfg   = cfg;
    cmd_mode  = mode;
    cmd_valid = 1'b1;
    cyc(1);
    if (hold > 0) begin
      cmd_op   = 3'd5;
      cmd_mode = 2'b11;
      cyc(hold);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (tx_seen < n && k < 200) begin
      cyc(1);
      k++;
    end
  endtask

  task automatic wait_rsp(input int n0);
    int k = 0;
    while (rsp_seen == n0 && k < 400) begin
      cyc(1);
      k++;
    end
    wait_ok  = rsp_seen != n0;
    chk_wait = 1'b1;
    cyc(1);
    chk_wait = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1);
  end

  initial begin
    int n0;
    int t0;
    cyc(3);
    idle_pins = 2'b00;
    chk_idle  = 1'b1;
    cyc(1);
    chk_idle  = 1'b0;
    rst_n     = 1'b1;
    cyc(2);

    // read config
    n0 = rsp_seen;
    repeat (3) tx_exp(8'hC1);
    rx_load(8'hC0); rx_load(8'h00); rx_load(8'h00);
    rx_load(8'h1A); rx_load(8'h17); rx_load(8'h44);
    rsp_exp(48'hC000001A1744, 1'b0, 2'b00);
    issue(3'd2, 40'h0, 2'b00, 0);
    wait_rsp(n0);

    // read version
    n0 = rsp_seen;
    repeat (3) tx_exp(8'hC3);
    rx_load(8'hC3); rx_load(8'h32); rx_load(8'h27); rx_load(8'h02);
    rsp_exp(48'hC33227020000, 1'b0, 2'b00);
    issue(3'd3, 40'h0, 2'b00, 0);
    wait_rsp(n0);

    // saved config write with back-pressure mid-stream
    n0 = rsp_seen;
    t0 = tx_seen;
    tx_exp(8'hC0); tx_exp(8'h00); tx_exp(8'h00);
    tx_exp(8'h1A); tx_exp(8'h17); tx_exp(8'h44);
    rsp_exp(48'h0, 1'b0, 2'b00);
    issue(3'd0, 40'h0000_1A17_44, 2'b00, 0);
    wait_tx(t0 + 2);
    tx_full = 1'b1;
    cyc(10);
    tx_full = 1'b0;
    wait_rsp(n0);

    // volatile config write; cmd_valid held while busy
    n0 = rsp_seen;
    tx_exp(8'hC2); tx_exp(8'h12); tx_exp(8'h34);
    tx_exp(8'h56); tx_exp(8'h78); tx_exp(8'h9A);
    rsp_exp(48'h0, 1'b0, 2'b00);
    issue(3'd1, 40'h12_3456_789A, 2'b00, 3);
    wait_rsp(n0);

    // set user mode 01, no UART traffic
    n0 = rsp_seen;
    rsp_exp(48'h0, 1'b0, 2'b01);
    issue(3'd5, 40'h0, 2'b01, 0);
    wait_rsp(n0);

    // module reset: AUX must dip low before completion
    n0 = rsp_seen;
    t0 = tx_seen;
    repeat (3) tx_exp(8'hC4);
    rsp_exp(48'h0, 1'b0, 2'b01);
    issue(3'd4, 40'h0, 2'b00, 0);
    wait_tx(t0 + 3);
    AUX = 1'b0;
    cyc(6);
    AUX = 1'b1;
    wait_rsp(n0);

    // short reply: timeout keeps partial data, pins restored
    n0 = rsp_seen;
    repeat (3) tx_exp(8'hC1);
    rx_load(8'hC0); rx_load(8'h00); rx_load(8'h00);
    rsp_exp(48'hC00000000000, 1'b1, 2'b01);
    issue(3'd2, 40'h0, 2'b00, 0);
    wait_rsp(n0);

    // reset during SEND byte 3
    t0 = tx_seen;
    tx_exp(8'hC0); tx_exp(8'h00); tx_exp(8'h00);
    issue(3'd0, 40'h0000_1A17_44, 2'b00, 0);
    wait_tx(t0 + 3);
    rst_n = 1'b0;
    cyc(1);
    idle_pins = 2'b00;
    chk_idle  = 1'b1;
    cyc(1);
    chk_idle  = 1'b0;
    rst_n     = 1'b1;
    cyc(4);

    // recovery after reset
    n0 = rsp_seen;
    repeat (3) tx_exp(8'hC3);
    rx_load(8'hC3); rx_load(8'h32); rx_load(8'h27); rx_load(8'h02);
    rsp_exp(48'hC33227020000, 1'b0, 2'b00);
    issue(3'd3, 40'h0, 2'b00, 0);
    wait_rsp(n0);

    cyc(5);
    chk_end = 1'b1;
    cyc(1);
    chk_end = 1'b0;
    cyc(1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
